pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Fetch-side consumer of the branch comparator's PCSrc decision. Holds the program
//  counter, issues sequential fetch requests to instruction memory over a valid/ready
//  handshake, and performs taken-branch/jump redirects. Emits a one-cycle pipeline
//  flush on every redirect. Holds a redirect that arrives during a stall until the
//  stall releases.
// PARAMETERS
//  PC_WIDTH  16      width of PC and branch target
//  RESET_PC  16'h0   PC value loaded on reset
//  PC_INC    2       byte increment per accepted fetch (16-bit instructions)
// PORTS
//  clk               in   1         rising-edge clock
//  rst               in   1         synchronous, active-high reset
//  PCSrc             in   1         redirect request from the comparator (1 = taken branch or jump)
//  branch_target     in   PC_WIDTH  redirect destination; sampled when PCSrc=1 is accepted
//  stall             in   1         hazard stall; freezes fetch
//  imem_ready        in   1         instruction memory accepts the current request
//  pc                out  PC_WIDTH  address of the current fetch request
//  pc_valid          out  1         fetch request valid
//  flush             out  1         squash IF/ID contents (registered, 1-cycle pulse)
//  redirect_pending  out  1         a captured redirect is waiting for stall to drop
//  align_err         out  1         1-cycle pulse: applied target had bit0=1
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc=RESET_PC, state=RUN, tgt_q=0. flush, redirect_pending
//    and align_err are 0 from the next cycle. pc_valid is forced to 0 while rst=1.
//  - States:
//    RUN   = normal fetch
//    WAIT  = redirect captured, stalled
//    BUB   = one-cycle squash bubble after a redirect
//  - pc_valid = (state==RUN) & ~stall & ~rst (combinational).
//  - accept   = pc_valid & imem_ready.
//  - RUN, evaluated in this priority order:
//    1. PCSrc & ~stall: pc<=target, flush<=1, ->BUB. The current request is dropped,
//       even if accept.
//    2. PCSrc & stall: tgt_q<=target, ->WAIT. pc is unchanged.
//    3. accept: pc<=pc+PC_INC.
//    4. Otherwise: hold pc.
//  - WAIT:
//    - redirect_pending=1.
//    - PCSrc is ignored; the first captured redirect wins because it comes from the
//      older instruction.
//    - When stall=0: pc<=tgt_q, flush<=1, ->BUB.
//  - BUB: pc_valid=0 and PCSrc is ignored (the wrong-path instruction is squashed).
//    ->RUN unconditionally next cycle.
//  - flush is high exactly one cycle: the cycle after the redirect transition. The
//    new pc is visible in that same cycle.
//  - Target alignment: bit0 of the applied target is forced to 0. align_err pulses in
//    the same cycle flush rises if the raw target bit0 was 1.
//  - Arithmetic: pc+PC_INC is mod 2^PC_WIDTH (16'hFFFE+2 -> 16'h0000). No error is
//    raised on wrap.
//  - imem_ready while pc_valid=0 has no effect.
//  - pc is stable while pc_valid=1 and imem_ready=0.
//  - rst mid-WAIT or mid-BUB discards tgt_q and returns to RUN at RESET_PC with no flush.
// TESTING
//  1. rst 2 cycles, imem_ready=1 for 4 cycles -> pc 0000,0002,0004,0006; pc_valid=1;
//     flush=0.
//  2. pc=0006, PCSrc=1, target=0040, stall=0 -> next cycle pc=0040, flush=1,
//     pc_valid=0; following cycle pc_valid=1, flush=0.
//  3. stall=1, PCSrc=1, target=0080, 3 stall cycles, then PCSrc=1 with target=00A0 ->
//     redirect_pending=1 throughout; pc unchanged. Stall drop -> pc=0080, flush pulse;
//     00A0 is never applied.
//  4. pc=FFFE, imem_ready=1 -> pc=0000.
//     imem_ready=0 for 3 cycles -> pc held at 0000, pc_valid=1.
//  5. PCSrc=1, target=0013 -> pc=0012, align_err=1 for one cycle with flush.
//  6. rst asserted while in WAIT -> pc=RESET_PC, redirect_pending=0, no flush pulse.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch-side program counter. Issues sequential fetch requests over a
//   valid/ready handshake and applies taken-branch/jump redirects from the
//   branch comparator. Every redirect produces a one-cycle flush pulse. A
//   redirect that arrives during a stall is held until the stall releases.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   PCSrc             redirect request (1 = taken branch or jump)
//   branch_target     redirect destination, sampled when PCSrc is accepted
//   stall             hazard stall, freezes fetch
//   imem_ready        instruction memory accepts the current request
//   pc                address of the current fetch request
//   pc_valid          fetch request valid (combinational)
//   flush             one-cycle squash of IF/ID, same cycle the new pc appears
//   redirect_pending  a captured redirect is waiting for the stall to drop
//   align_err         one-cycle pulse with flush when the raw target had bit0=1
module pc_redirect_unit #(
  parameter int unsigned             PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0,
  parameter int unsigned             PC_INC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCSrc,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stall,
  input  logic                imem_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic                flush,
  output logic                redirect_pending,
  output logic                align_err
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUB  = 2'd2
  } state_t;

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   r_tgt;
  logic                  r_flush;
  logic                  r_align_err;

  logic                  w_pc_valid;
  logic                  w_accept;
  logic [PC_WIDTH-1:0]   w_pc_next_seq;
  logic [PC_WIDTH-1:0]   w_tgt_in_aligned;
  logic [PC_WIDTH-1:0]   w_tgt_q_aligned;

  // Request is only offered in RUN; reset masks it immediately.
  assign w_pc_valid    = (r_state == ST_RUN) & ~stall & ~rst;
  assign w_accept      = w_pc_valid & imem_ready;
  assign w_pc_next_seq = r_pc + PC_WIDTH'(PC_INC);

  // Instructions are 16-bit, so bit0 of any applied target is dropped.
  assign w_tgt_in_aligned = {branch_target[PC_WIDTH-1:1], 1'b0};
  assign w_tgt_q_aligned  = {r_tgt[PC_WIDTH-1:1], 1'b0};

  // State, pc, captured target and the pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_tgt       <= '0;
      r_flush     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_flush     <= 1'b0;
      r_align_err <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // A redirect outranks a same-cycle accept: that request is wrong-path.
          if (PCSrc && !stall) begin
            r_pc        <= w_tgt_in_aligned;
            r_flush     <= 1'b1;
            r_align_err <= branch_target[0];
            r_state     <= ST_BUB;
          end else if (PCSrc && stall) begin
            r_tgt   <= branch_target;
            r_state <= ST_WAIT;
          end else if (w_accept) begin
            r_pc <= w_pc_next_seq;
          end
        end
        ST_WAIT: begin
          // Later PCSrc pulses come from younger instructions and are ignored.
          if (!stall) begin
            r_pc        <= w_tgt_q_aligned;
            r_flush     <= 1'b1;
            r_align_err <= r_tgt[0];
            r_state     <= ST_BUB;
          end
        end
        ST_BUB: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign pc               = r_pc;
  assign pc_valid         = w_pc_valid;
  assign flush            = r_flush;
  assign redirect_pending = (r_state == ST_WAIT);
  assign align_err        = r_align_err;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit
//   Directed scenarios for pc_redirect_unit. Each cycle the bench drives
//   inputs on the falling edge, pushes the expected outputs onto a scoreboard
//   queue, and pops/compares them a little later in the same low phase.
module tb_pc_redirect_unit;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          PCSrc;
  logic [W-1:0]  branch_target;
  logic          stall;
  logic          imem_ready;
  logic [W-1:0]  pc;
  logic          pc_valid;
  logic          flush;
  logic          redirect_pending;
  logic          align_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected observation layout: {pc, pc_valid, flush, redirect_pending, align_err}
  typedef logic [W+3:0] obs_t;

  typedef struct {
    logic         r;
    logic         p;
    logic [W-1:0] t;
    logic         s;
    logic         rd;
    obs_t         exp;
  } vec_t;

  obs_t sb[$];

  pc_redirect_unit #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000),
    .PC_INC   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PCSrc            (PCSrc),
    .branch_target    (branch_target),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .align_err        (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic p, logic [W-1:0] t, logic s, logic rd,
                              logic [W-1:0] epc, logic ev, logic ef, logic ep, logic ea);
    vec_t v;
    v.r = r; v.p = p; v.t = t; v.s = s; v.rd = rd;
    v.exp = {epc, ev, ef, ep, ea};
    return v;
  endfunction

  function automatic obs_t observe();
    return {pc, pc_valid, flush, redirect_pending, align_err};
  endfunction

  // Apply one cycle of stimulus and queue its expected outputs.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst           = v.r;
    PCSrc         = v.p;
    branch_target = v.t;
    stall         = v.s;
    imem_ready    = v.rd;
    sb.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 16'h1234, 0, 1, 16'h0000, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_seq_fetch();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0002, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0006, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_redirect();
    vec_t v[$];
    obs_t e, o;
    // Redirect beats a same-cycle accept; BUB ignores PCSrc and imem_ready.
    v.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h0008, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 16'h0100, 0, 1, 16'h0040, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0040, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0042, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_stall_redirect();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(0, 1, 16'h0080, 1, 1, 16'h0044, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0044, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0044, 0, 0, 1, 0));
    v.push_back(mk(0, 1, 16'h00A0, 1, 1, 16'h0044, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0044, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0080, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0080, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0082, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_redirect[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_wrap_hold();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(0, 1, 16'hFFFE, 0, 0, 16'h0082, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'hFFFE, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hFFFE, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_hold[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_align();
    vec_t v[$];
    obs_t e, o;
    // Odd target taken directly, then an odd target applied from WAIT.
    v.push_back(mk(0, 1, 16'h0013, 0, 0, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0012, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0012, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 16'h0021, 1, 1, 16'h0014, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0014, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0020, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0020, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL align[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    vec_t v[$];
    obs_t e, o;
    // Reset in WAIT drops the captured target; reset in BUB restarts cleanly.
    v.push_back(mk(0, 1, 16'h0300, 1, 0, 16'h0020, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0020, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0020, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 16'h0050, 0, 0, 16'h0002, 1, 0, 0, 0));
    v.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0050, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_redirect[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    obs_t e, o;
    v.push_back(mk(0, 1, 16'h0100, 0, 0, 16'h0000, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 16'h0200, 0, 0, 16'h0100, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 16'h0300, 0, 0, 16'h0100, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0300, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0300, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0302, 1, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      #2;
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got pc=%h v=%b f=%b p=%b a=%b, want pc=%h v=%b f=%b p=%b a=%b",
                 i, o[W+3:4], o[3], o[2], o[1], o[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    PCSrc         = 1'b0;
    branch_target = '0;
    stall         = 1'b0;
    imem_ready    = 1'b0;

    test_reset();
    test_seq_fetch();
    test_redirect();
    test_stall_redirect();
    test_wrap_hold();
    test_align();
    test_reset_mid_redirect();
    test_back_to_back();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
